pipe_stage_reg: RTL



---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid + opaque payload, stall/bubble control,
// optional one-entry skid buffer with back-pressure, saturating event counters.
module pipe_stage_reg #(
    parameter int PAYLOAD_W = 32,
    parameter int SKID      = 0,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 bubble_i,
    input  logic                 in_valid_i,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    output logic                 in_ready_o,
    output logic                 out_valid_o,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    logic                 mv_q, mv_d;
    logic [PAYLOAD_W-1:0] md_q, md_d;
    logic                 sv_q, sv_d;
    logic [PAYLOAD_W-1:0] sd_q, sd_d;
    logic                 rdy_q, rdy_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic                 accept;

    // One extra bit of headroom catches the carry out; a carry means clamp.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) sat_add = {CNT_W{1'b1}};
        else            sat_add = sum[CNT_W-1:0];
    endfunction

    assign accept = in_valid_i & ((SKID != 0) ? rdy_q : 1'b1);

    always_comb begin
        mv_d        = mv_q;
        md_d        = md_q;
        sv_d        = sv_q;
        sd_d        = sd_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (rst_i) begin
            mv_d        = 1'b0;
            md_d        = '0;
            sv_d        = 1'b0;
            sd_d        = '0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else if (bubble_i) begin
            mv_d        = 1'b0;
            md_d        = '0;
            sv_d        = 1'b0;
            sd_d        = '0;
            flush_cnt_d = sat_add(flush_cnt_q, {1'b0, mv_q} + {1'b0, sv_q});
        end else begin
            if (stall_i && mv_q)
                stall_cnt_d = sat_add(stall_cnt_q, 2'd1);

            if (SKID == 0) begin
                if (!stall_i) begin
                    mv_d = in_valid_i;
                    md_d = in_payload_i;
                end
            end else if (!stall_i) begin
                // The skid entry always drains before anything new is taken.
                if (sv_q) begin
                    mv_d = 1'b1;
                    md_d = sd_q;
                    sv_d = 1'b0;
                end else if (accept) begin
                    mv_d = 1'b1;
                    md_d = in_payload_i;
                end else begin
                    mv_d = 1'b0;
                end
            end else if (accept) begin
                if (!mv_q) begin
                    mv_d = 1'b1;
                    md_d = in_payload_i;
                end else begin
                    sv_d = 1'b1;
                    sd_d = in_payload_i;
                end
            end
        end

        rdy_d = ~sv_d;
    end

    always_ff @(posedge clk_i) begin
        mv_q        <= mv_d;
        md_q        <= md_d;
        sv_q        <= sv_d;
        sd_q        <= sd_d;
        rdy_q       <= rdy_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign in_ready_o    = (SKID != 0) ? rdy_q : 1'b1;
    assign out_valid_o   = mv_q;
    assign out_payload_o = md_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule
